// File: rtl/cash_handler.sv
// cash_handler: customer credit / machine cash accounting for the vending machine.
// One operation per rising clock edge, selected by {mode, func}:
//   00 purchase, 01 charge customer, 10 charge machine, 11 withdraw from machine.
// Optional build macro: CASH_HANDLER_SATURATE_EN
//   defined   -> an add that would exceed 2^BAL_W-1 is rejected (no state change)
//   undefined -> adds wrap modulo 2^BAL_W and are always accepted
// All outputs are registered; reset is asynchronous and active-low.
module cash_handler #(
  parameter int BAL_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             mode,
  input  logic             func,
  input  logic [10:0]      amount,
  output logic             res,
  output logic [BAL_W-1:0] customer_bal,
  output logic [BAL_W-1:0] machine_bal
);

  typedef enum logic [1:0] {
    OP_PURCHASE    = 2'b00,
    OP_CHARGE_CUST = 2'b01,
    OP_CHARGE_MACH = 2'b10,
    OP_WITHDRAW    = 2'b11
  } op_e;

  op_e              op;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W-1:0] cust_sum;
  logic [BAL_W-1:0] mach_sum;
  logic             cust_add_ok;
  logic             mach_add_ok;
  logic             cust_covers;
  logic             mach_covers;

  logic             res_nxt;
  logic [BAL_W-1:0] customer_bal_nxt;
  logic [BAL_W-1:0] machine_bal_nxt;

  assign op      = op_e'({mode, func});
  assign amt_ext = BAL_W'(amount);

`ifdef CASH_HANDLER_SATURATE_EN
  // Carry out of each add marks an overflow, which makes the add illegal.
  logic cust_carry;
  logic mach_carry;
  assign {cust_carry, cust_sum} = {1'b0, customer_bal} + {1'b0, amt_ext};
  assign {mach_carry, mach_sum} = {1'b0, machine_bal} + {1'b0, amt_ext};
  assign cust_add_ok = ~cust_carry;
  assign mach_add_ok = ~mach_carry;
`else
  // Wrapping adds: every add is legal.
  assign cust_sum    = customer_bal + amt_ext;
  assign mach_sum    = machine_bal + amt_ext;
  assign cust_add_ok = 1'b1;
  assign mach_add_ok = 1'b1;
`endif

  assign cust_covers = (customer_bal >= amt_ext);
  assign mach_covers = (machine_bal >= amt_ext);

  // Decode the operation; a rejected operation leaves both balances untouched.
  always_comb begin
    res_nxt          = 1'b0;
    customer_bal_nxt = customer_bal;
    machine_bal_nxt  = machine_bal;
    unique case (op)
      OP_PURCHASE: begin
        if (cust_covers && mach_add_ok) begin
          customer_bal_nxt = customer_bal - amt_ext;
          machine_bal_nxt  = mach_sum;
          res_nxt          = 1'b1;
        end
      end
      OP_CHARGE_CUST: begin
        if (cust_add_ok) begin
          customer_bal_nxt = cust_sum;
          res_nxt          = 1'b1;
        end
      end
      OP_CHARGE_MACH: begin
        if (mach_add_ok) begin
          machine_bal_nxt = mach_sum;
          res_nxt         = 1'b1;
        end
      end
      OP_WITHDRAW: begin
        if (mach_covers) begin
          machine_bal_nxt = machine_bal - amt_ext;
          res_nxt         = 1'b1;
        end
      end
      default: begin
        res_nxt = 1'b0;
      end
    endcase
  end

  // Balance and result registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res          <= 1'b0;
      customer_bal <= '0;
      machine_bal  <= '0;
    end else begin
      res          <= res_nxt;
      customer_bal <= customer_bal_nxt;
      machine_bal  <= machine_bal_nxt;
    end
  end

endmodule

// File: tb/tb_cash_handler.sv
// Testbench for cash_handler: directed scenarios plus randomized operations,
// checked through a scoreboard queue fed by a balance-level reference model.
module tb_cash_handler;
  localparam int     BAL_W = 16;
  localparam longint LIM   = longint'(1) << BAL_W;
`ifdef CASH_HANDLER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             mode = 1'b0;
  logic             func = 1'b0;
  logic [10:0]      amount = '0;
  logic             res;
  logic [BAL_W-1:0] customer_bal;
  logic [BAL_W-1:0] machine_bal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string  name;
    bit     res;
    longint cust;
    longint mach;
  } exp_t;

  exp_t   sb[$];
  longint m_cust = 0;
  longint m_mach = 0;

  always #5 clock = ~clock;

  cash_handler #(.BAL_W(BAL_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mode         (mode),
    .func         (func),
    .amount       (amount),
    .res          (res),
    .customer_bal (customer_bal),
    .machine_bal  (machine_bal)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: balances as plain integers, rules applied arithmetically.
  task automatic model(input bit md, input bit fn, input longint a, output bit r);
    r = 1'b0;
    case ({md, fn})
      2'b00: if (a <= m_cust && (!SAT || m_mach + a < LIM)) begin
        m_cust = m_cust - a;
        m_mach = (m_mach + a) % LIM;
        r = 1'b1;
      end
      2'b01: if (!SAT || m_cust + a < LIM) begin
        m_cust = (m_cust + a) % LIM;
        r = 1'b1;
      end
      2'b10: if (!SAT || m_mach + a < LIM) begin
        m_mach = (m_mach + a) % LIM;
        r = 1'b1;
      end
      default: if (a <= m_mach) begin
        m_mach = m_mach - a;
        r = 1'b1;
      end
    endcase
  endtask

  task automatic push_exp(input string name, input bit r);
    exp_t e;
    e.name = name;
    e.res  = r;
    e.cust = m_cust;
    e.mach = m_mach;
    sb.push_back(e);
  endtask

  // Drive one operation for the next rising edge and record its expected outcome.
  task automatic do_op(input bit md, input bit fn, input int a, input string name);
    bit r;
    @(negedge clock);
    mode   = md;
    func   = fn;
    amount = a[10:0];
    model(md, fn, longint'(a), r);
    push_exp(name, r);
  endtask

  // Called at a negedge: release reset; the following edge runs an amount=0 op.
  task automatic release_reset();
    bit r;
    amount  = '0;
    reset_n = 1'b1;
    model(mode, func, 0, r);
    push_exp("post_reset", r);
  endtask

  // Reset asserted between edges, optionally after new operands were applied.
  task automatic async_reset(input bit with_op);
    @(negedge clock);
    if (with_op) begin
      mode   = 1'b0;
      func   = 1'b1;
      amount = 11'd100;
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_res", res, 0);
    check("async_rst_cust", customer_bal, 0);
    check("async_rst_mach", machine_bal, 0);
    m_cust = 0;
    m_mach = 0;
    @(negedge clock);
    check("rst_hold_cust", customer_bal, 0);
    release_reset();
  endtask

  // Monitor: every edge that has a pending expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "_res"}, res, e.res);
        check({e.name, "_cust"}, customer_bal, e.cust);
        check({e.name, "_mach"}, machine_bal, e.mach);
      end
    end
  end

  initial begin
    int pick;
    int a;
    #1;
    check("reset_res", res, 0);
    check("reset_cust", customer_bal, 0);
    check("reset_mach", machine_bal, 0);
    @(negedge clock);
    release_reset();

    do_op(0, 0, 3, "buy_empty");
    do_op(0, 1, 7, "charge7");
    do_op(0, 0, 3, "buy3");
    do_op(1, 1, 10, "wd_short");
    do_op(1, 0, 10, "deposit10");
    do_op(1, 1, 10, "wd10");
    for (int i = 0; i < 3; i++) do_op(0, 1, 5, "hold_charge5");
    do_op(1, 1, 0, "wd_zero");
    do_op(0, 0, 0, "buy_zero");

    async_reset(1'b1);

    for (int i = 0; i < 32; i++) do_op(0, 1, 2047, "fill_cust");
    do_op(0, 1, 26, "fill_cust_top");
    do_op(0, 1, 10, "cust_overflow");
    for (int i = 0; i < 32; i++) do_op(1, 0, 2047, "fill_mach");
    do_op(1, 0, 26, "fill_mach_top");
    do_op(1, 0, 10, "mach_overflow");
    do_op(0, 0, 5, "buy_to_top");
    do_op(0, 0, 1, "buy_over_top");
    do_op(0, 1, 0, "charge_zero_full");

    async_reset(1'b0);

    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 2) begin
        async_reset(pick[0]);
      end else begin
        if (pick < 22) a = 0;
        else if (pick < 40) a = 2047;
        else a = int'($urandom_range(0, 2047));
        do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, "rand");
      end
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
